aes_key_expand: RTL
===================

# aes_key_expand

Iterative AES-128 key schedule generator that expands a 128-bit cipher key into the 11 round keys. It sits upstream of the AddRoundKey/round datapath and streams one round key per accepted handshake. SubWord is computed with four instances of the existing byte S-box (`Sub_byte`) on the rotated last word.

## Interface
- No parameters; AES-128 only.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin an expansion; sampled only when busy=0.
- key_in  in  [0:127]  cipher key; bit 0 is the MSB of byte 0; sampled with start.
- rk_ready  in  1  downstream accepts the current round key.
- rk_valid  out  1  round_key/round_idx are valid.
- round_key  out  [0:127]  round key w[4r..4r+3]; byte 0 in bits [0:7].
- round_idx  out  [3:0]  round number r, 0..10.
- busy  out  1  expansion in progress.
- done  out  1  one-cycle pulse after the round-10 key is accepted.
- rd_idx  in  [3:0]  random-access read index (see Configuration).
- rd_key  out  [0:127]  random-access read data (see Configuration).

## Operation
- States: IDLE, RUN.
- IDLE: busy=0, rk_valid=0. On start=1, load key_in into key register, round_idx<=0, rcon<=8'h01, go to RUN.
- RUN: busy=1, rk_valid=1, round_key = key register.
  - On rk_valid && rk_ready with round_idx<10: key register <= next key, round_idx increments, rcon advances.
  - On rk_valid && rk_ready with round_idx=10: go to IDLE, done=1 for the following cycle.
  - rk_ready=0: hold all outputs stable (stall of any length).
- Next key, words w0..w3 of the current key: t = SubWord(RotWord(w3)) ^ {rcon,8'h00,8'h00,8'h00}; n0=w0^t; n1=w1^n0; n2=w2^n1; n3=w3^n2. RotWord moves byte 0 to byte 3.
- Rcon sequence: 01,02,04,08,10,20,40,80,1B,36; next = xtime(rcon) = {rcon[6:0],1'b0} ^ (rcon[7] ? 8'h1B : 8'h00).
- start while busy=1 is ignored; key_in changes while busy do not affect the expansion.
- start in the same cycle done is high (state IDLE) is accepted.

## Timing
- Reset values: rk_valid=0, busy=0, done=0, round_key=0, round_idx=0, internal rcon=8'h01, state IDLE.
- Reset asserted mid-expansion aborts immediately; all outputs return to their reset values; no done pulse.
- start in cycle N -> rk_valid=1, round_idx=0 in cycle N+1.
- With rk_ready held high, one key per cycle: round r is presented in cycle N+1+r; done=1 in cycle N+12; busy=0 from cycle N+12.
- Next-key logic is purely combinational from the key register (four S-box lookups plus XOR chain) and is registered on handshake; one cycle per round.

## Configuration
- KEY_EXP_STORE_EN defined: an 11x128 register file captures each round key when it is handshaken (index round_idx). rd_key = stored[rd_idx] combinationally. rd_idx>10 returns 0. Contents are cleared on reset and retained across expansions until overwritten. This supports reverse-order access for decryption.
- KEY_EXP_STORE_EN undefined: no storage is built; rd_key is tied to 0 and rd_idx is ignored.

## Test plan
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c with rk_ready=1 -> round 0 = key; round 1 = a0fafe1788542cb123a339392a6c7605; round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6; done 12 cycles after start.
- Same key with rk_ready toggled randomly -> identical key sequence; outputs stable while rk_ready=0; no round skipped or repeated.
- All-zero key -> round 1 = 62636363626363636263636362636363; round 10 = b4ef5bcb3e92e21123e951cf6f8f188e.
- start pulsed with a different key_in at round 5 -> ignored; the sequence completes for the original key.
- rst_n asserted at round 3 -> rk_valid, busy, and done drop to 0 asynchronously; a new start afterwards produces a correct sequence from round 0.
- KEY_EXP_STORE_EN defined, after the FIPS run -> rd_idx=10 gives d014f9a8c9ee2589e13f0cc8b6630ca6 and rd_idx=15 gives 0. Without the macro, rd_key=0 for every rd_idx.

Source files
------------

// File: rtl/aes_key_expand.sv
// Purpose : iterative AES-128 key schedule; expands a cipher key into round keys 0..10, one per handshake.
// Latency : round 0 is valid the cycle after start; with rk_ready held high one key per cycle, done 12 cycles after start.
// Backpr. : rk_ready=0 stalls the schedule indefinitely with round_key/round_idx held stable.
//
// Ports: clk, rst_n (async active-low); start/key_in request an expansion (ignored while busy);
//        rk_valid/rk_ready handshake round_key (byte 0 in bits [0:7]) tagged with round_idx;
//        busy while expanding, done pulses one cycle after round 10 is accepted;
//        rd_idx/rd_key random-access read of stored round keys.
// Optional: define KEY_EXP_STORE_EN to build the 11x128 round-key store behind rd_idx/rd_key;
//           without it rd_key reads as 0.
`timescale 1ns/1ps

// AES forward S-box, one byte, purely combinational table lookup.
module Sub_byte (
    input  logic [7:0] din,
    output logic [7:0] dout
);
    // Entry 0 sits in the top byte so the table reads in natural order.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic [10:0] msb;
    assign msb  = 11'd2047 - {din, 3'b000};
    assign dout = SBOX[msb -: 8];
endmodule

module aes_key_expand (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [0:127] key_in,
    input  logic         rk_ready,
    output logic         rk_valid,
    output logic [0:127] round_key,
    output logic [3:0]   round_idx,
    output logic         busy,
    output logic         done,
    input  logic [3:0]   rd_idx,
    output logic [0:127] rd_key
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t       state_q;
    logic [127:0] key_q;     // byte 0 in [127:120], matching round_key bit 0 = MSB
    logic [127:0] next_key;
    logic [7:0]   rcon_q;
    logic [7:0]   rcon_next;
    logic [3:0]   idx_q;
    logic         valid_q;
    logic         busy_q;
    logic         done_q;
    logic         hs;

    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  rot_w3;
    logic [31:0]  sub_w3;
    logic [31:0]  t;
    logic [31:0]  n0, n1, n2, n3;

    assign w0 = key_q[127:96];
    assign w1 = key_q[95:64];
    assign w2 = key_q[63:32];
    assign w3 = key_q[31:0];

    // RotWord: byte 0 of w3 moves to byte 3.
    assign rot_w3 = {w3[23:0], w3[31:24]};

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        Sub_byte u_sub (
            .din  (rot_w3[8*b +: 8]),
            .dout (sub_w3[8*b +: 8])
        );
    end

    assign t  = sub_w3 ^ {rcon_q, 24'h000000};
    assign n0 = w0 ^ t;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;
    assign next_key = {n0, n1, n2, n3};

    // xtime in GF(2^8): 01,02,...,80,1b,36
    assign rcon_next = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);

    assign hs = valid_q & rk_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            key_q   <= '0;
            rcon_q  <= 8'h01;
            idx_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        key_q   <= key_in;
                        rcon_q  <= 8'h01;
                        idx_q   <= '0;
                        valid_q <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (hs) begin
                        if (idx_q == 4'd10) begin
                            // key_q/round_idx keep the last round; rk_valid=0 marks them stale.
                            valid_q <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            key_q  <= next_key;
                            idx_q  <= idx_q + 4'd1;
                            rcon_q <= rcon_next;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rk_valid  = valid_q;
    assign round_key = key_q;
    assign round_idx = idx_q;
    assign busy      = busy_q;
    assign done      = done_q;

`ifdef KEY_EXP_STORE_EN
    // Keeps every accepted round key so decryption can walk them in reverse.
    logic [127:0] store_q [0:10];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 11; i++) begin
                store_q[i] <= '0;
            end
        end else if (hs) begin
            store_q[idx_q] <= key_q;
        end
    end

    assign rd_key = (rd_idx <= 4'd10) ? store_q[rd_idx] : '0;
`else
    logic unused_rd_idx;
    assign unused_rd_idx = ^rd_idx;
    assign rd_key        = '0;
`endif

endmodule
